// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32I pipeline.
// Owns load-use bubbles, LSU waits, redirect flushes, debug drain/halt and stall counting.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int DRAIN_CYC   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_rd_wren,
  input  logic             i_ex_is_load,
  input  logic             i_ex_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  input  logic             i_halt_req,
  input  logic             i_resume,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_mem_timeout
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_MWAIT = 2'b01,
    S_DRAIN = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0]    drn_cnt_q, drn_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_tmo_q, mem_tmo_d;

  logic hz_lu;
  logic mwait;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_fl, idex_fl;

  // Load-use hazard against EX and the LSU wait condition.
  always_comb begin
    hz_lu = i_ex_is_load & i_ex_rd_wren & (i_ex_rd_addr != 5'd0) &
            ((i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr)) |
             (i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr)));
    mwait = i_mem_req & ~i_mem_ready;
  end

  // Stage enables, flush strobes and next state from state and hazards.
  always_comb begin
    pc_en     = 1'b0;
    ifid_en   = 1'b0;
    idex_en   = 1'b0;
    exmem_en  = 1'b0;
    memwb_en  = 1'b0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    state_d   = state_q;
    drn_cnt_d = drn_cnt_q;
    unique case (state_q)
      S_RUN, S_MWAIT: begin
        if (mwait) begin
          state_d = S_MWAIT;
        end else begin
          state_d = S_RUN;
          priority case (1'b1)
            i_ex_redirect: begin
              pc_en    = 1'b1;
              ifid_en  = 1'b1;
              idex_en  = 1'b1;
              exmem_en = 1'b1;
              memwb_en = 1'b1;
              ifid_fl  = 1'b1;
              idex_fl  = 1'b1;
            end
            hz_lu: begin
              idex_en  = 1'b1;
              exmem_en = 1'b1;
              memwb_en = 1'b1;
              idex_fl  = 1'b1;
            end
            i_halt_req: begin
              ifid_en   = 1'b1;
              idex_en   = 1'b1;
              exmem_en  = 1'b1;
              memwb_en  = 1'b1;
              ifid_fl   = 1'b1;
              state_d   = S_DRAIN;
              drn_cnt_d = '0;
            end
            default: begin
              pc_en    = 1'b1;
              ifid_en  = 1'b1;
              idex_en  = 1'b1;
              exmem_en = 1'b1;
              memwb_en = 1'b1;
            end
          endcase
        end
      end
      S_DRAIN: begin
        if (!mwait) begin
          ifid_en   = 1'b1;
          idex_en   = 1'b1;
          exmem_en  = 1'b1;
          memwb_en  = 1'b1;
          ifid_fl   = 1'b1;
          idex_fl   = i_ex_redirect;
          drn_cnt_d = drn_cnt_q + 1'b1;
          if (drn_cnt_d == DW'(DRAIN_CYC)) begin
            state_d   = S_HALT;
            drn_cnt_d = '0;
          end
        end
      end
      S_HALT: begin
        if (i_resume && !i_halt_req) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    if (!i_rst_n) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
    end
  end

  // Wait-length tracking, sticky timeout and saturating stall count.
  always_comb begin
    tmo_cnt_d   = '0;
    mem_tmo_d   = mem_tmo_q;
    stall_cnt_d = stall_cnt_q;
    if (mwait && state_q != S_HALT) begin
      if (tmo_cnt_q == TW'(MEM_TIMEOUT)) tmo_cnt_d = tmo_cnt_q;
      else tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (MEM_TIMEOUT != 0 && tmo_cnt_d == TW'(MEM_TIMEOUT)) mem_tmo_d = 1'b1;
    end
    if (!pc_en && state_q != S_HALT && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_RUN;
      tmo_cnt_q   <= '0;
      drn_cnt_q   <= '0;
      stall_cnt_q <= '0;
      mem_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      drn_cnt_q   <= drn_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_tmo_q   <= mem_tmo_d;
    end
  end

  assign o_pc_en       = pc_en;
  assign o_ifid_en     = ifid_en;
  assign o_idex_en     = idex_en;
  assign o_exmem_en    = exmem_en;
  assign o_memwb_en    = memwb_en;
  assign o_ifid_flush  = ifid_fl;
  assign o_idex_flush  = idex_fl;
  assign o_state       = state_q;
  assign o_stall_cnt   = stall_cnt_q;
  assign o_mem_timeout = mem_tmo_q;

endmodule
